// File: rtl/bin_img_stream_tx.sv
// bin_img_stream_tx
//   Reads a stored 1-bit frame from a synchronous RAM in raster order. The frame
//   is sent as a vsync/hsync/valid/bit stream, with lead, line-gap and tail
//   blanking. One frame is sent per accepted start pulse, and pix_en paces the
//   pixels inside an active line.
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle frame request, accepted only while busy=0
//   pix_en            pixel pacing inside a line (0 inserts a gap cycle)
//   mem_rd_en         RAM read strobe, combinational from the FSM registers and pix_en
//   mem_addr          RAM read address, y*H_ACT + x
//   mem_rd_data       RAM read data, valid the cycle after mem_rd_en
//   post_frame_vsync  high for the whole frame
//   post_frame_hsync  high across each active line, including pix_en gaps
//   post_frame_valid  high on cycles that carry a pixel
//   post_img_bit      pixel value, forced to 0 when not valid
//   busy              a frame is in progress, including the output pipeline drain
//   frame_done        one-cycle pulse on the first cycle vsync is low after a frame
module bin_img_stream_tx #(
  parameter int unsigned H_ACT   = 640,
  parameter int unsigned V_ACT   = 480,
  parameter int unsigned H_BLANK = 16,
  parameter int unsigned V_LEAD  = 8,
  parameter int unsigned V_TAIL  = 8,
  parameter int unsigned ADDR_W  = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_data,
  output logic              post_frame_vsync,
  output logic              post_frame_hsync,
  output logic              post_frame_valid,
  output logic              post_img_bit,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned X_W     = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int unsigned Y_W     = (V_ACT > 1) ? $clog2(V_ACT) : 1;
  localparam int unsigned CNT_MAX = (V_LEAD > H_BLANK) ?
                                    ((V_LEAD > V_TAIL) ? V_LEAD : V_TAIL) :
                                    ((H_BLANK > V_TAIL) ? H_BLANK : V_TAIL);
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LEAD = 3'd1;
  localparam logic [2:0] ST_LINE = 3'd2;
  localparam logic [2:0] ST_HGAP = 3'd3;
  localparam logic [2:0] ST_TAIL = 3'd4;

  localparam logic [X_W-1:0]   LAST_X    = X_W'(H_ACT - 1);
  localparam logic [Y_W-1:0]   LAST_Y    = Y_W'(V_ACT - 1);
  localparam logic [CNT_W-1:0] LAST_LEAD = CNT_W'(V_LEAD - 1);
  localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'(H_BLANK - 1);
  localparam logic [CNT_W-1:0] LAST_TAIL = CNT_W'(V_TAIL - 1);

  logic [2:0]        state, state_nxt;
  logic [X_W-1:0]    x, x_nxt;
  logic [Y_W-1:0]    y, y_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;

  logic s1_vsync, s1_hsync, s1_valid;
  logic start_acc_c;
  logic done_set_c;

  // A new frame is only taken once the previous one has fully drained.
  assign start_acc_c = (state == ST_IDLE) & start & ~busy;

  // Vsync drops at the pipeline output while stage 1 already shows idle.
  assign done_set_c  = post_frame_vsync & ~s1_vsync;

  assign mem_rd_en   = (state == ST_LINE) & pix_en;
  assign mem_addr    = addr;

  // FSM and counter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      x     <= '0;
      y     <= '0;
      cnt   <= '0;
      addr  <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      y     <= y_nxt;
      cnt   <= cnt_nxt;
      addr  <= addr_nxt;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    y_nxt     = y;
    cnt_nxt   = cnt;
    addr_nxt  = addr;
    case (state)
      ST_IDLE: begin
        if (start_acc_c) begin
          state_nxt = ST_LEAD;
          x_nxt     = '0;
          y_nxt     = '0;
          cnt_nxt   = '0;
          addr_nxt  = '0;
        end
      end
      ST_LEAD: begin
        if (cnt == LAST_LEAD) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_LINE: begin
        // Each pixel is one RAM read. Without pix_en the line stalls in place.
        if (pix_en) begin
          if (x == LAST_X) begin
            x_nxt = '0;
            if (y == LAST_Y) begin
              state_nxt = ST_TAIL;
              addr_nxt  = '0;
            end else begin
              state_nxt = ST_HGAP;
              addr_nxt  = addr + ADDR_W'(1);
            end
          end else begin
            x_nxt    = x + X_W'(1);
            addr_nxt = addr + ADDR_W'(1);
          end
        end
      end
      ST_HGAP: begin
        if (cnt == LAST_GAP) begin
          state_nxt = ST_LINE;
          cnt_nxt   = '0;
          y_nxt     = y + Y_W'(1);
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_TAIL: begin
        if (cnt == LAST_TAIL) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Framing passes through two register stages. Pixel data joins at stage 2,
  // one cycle after its read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vsync         <= 1'b0;
      s1_hsync         <= 1'b0;
      s1_valid         <= 1'b0;
      post_frame_vsync <= 1'b0;
      post_frame_hsync <= 1'b0;
      post_frame_valid <= 1'b0;
      post_img_bit     <= 1'b0;
    end else begin
      s1_vsync         <= (state != ST_IDLE);
      s1_hsync         <= (state == ST_LINE);
      s1_valid         <= mem_rd_en;
      post_frame_vsync <= s1_vsync;
      post_frame_hsync <= s1_hsync;
      post_frame_valid <= s1_valid;
      post_img_bit     <= s1_valid & mem_rd_data;
    end
  end

  // busy covers the FSM and the pipeline drain, and falls together with frame_done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= done_set_c;
      if (start_acc_c) begin
        busy <= 1'b1;
      end else if (done_set_c) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bin_img_stream_tx.sv
// Bench for bin_img_stream_tx on a 4x3 checkerboard frame.
// Per-cycle framing traces are compared against a schedule model. A monitor
// pops expected pixels from a scoreboard and tracks the read address.
module tb_bin_img_stream_tx;

  localparam int unsigned H  = 4;
  localparam int unsigned V  = 3;
  localparam int unsigned HB = 2;
  localparam int unsigned VL = 3;
  localparam int unsigned VT = 2;
  localparam int unsigned AW = 4;
  localparam int N = 64;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          pix_en;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_data;
  logic          vs, hs, val, bitv, busy, done;

  bin_img_stream_tx #(
    .H_ACT(H), .V_ACT(V), .H_BLANK(HB), .V_LEAD(VL), .V_TAIL(VT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_en(pix_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .post_frame_vsync(vs), .post_frame_hsync(hs), .post_frame_valid(val),
    .post_img_bit(bitv), .busy(busy), .frame_done(done)
  );

  always #5 clk = ~clk;

  // Checkerboard rows 1010 / 0101 / 1010, first pixel in the MSB
  logic [11:0] pattern = 12'b1010_0101_1010;
  logic        ram [0:15];
  initial begin
    for (int a = 0; a < 16; a++) ram[a] = (a < 12) ? pattern[11 - a] : 1'b0;
  end
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= ram[int'(mem_addr)];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Scoreboard of expected pixel bits, plus the expected next read address
  logic          sb_q[$];
  logic [AW-1:0] exp_addr = '0;

  task automatic sb_push();
    for (int a = 0; a < 12; a++) sb_q.push_back(pattern[11 - a]);
    exp_addr = '0;
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (mem_rd_en) begin
        chk("addr", 64'(mem_addr), 64'(exp_addr));
        exp_addr = exp_addr + AW'(1);
      end
      if (val) begin
        if (sb_q.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else chk("pix", 64'(bitv), 64'(sb_q.pop_front()));
      end else if (hs) begin
        chk("gap_bit", 64'(bitv), 64'(0));
      end
    end
  end

  // Stimulus vectors indexed by the cycle offset k from the first start (t0+k)
  logic [N-1:0] st_v, acc_v, pen_v;
  logic [N-1:0] tr_vs, tr_hs, tr_val, tr_rd, tr_done, tr_busy;
  logic [N-1:0] ex_vs, ex_hs, ex_val, ex_rd, ex_done, ex_busy;

  task automatic clear_vectors();
    st_v = '0; acc_v = '0; pen_v = '1;
    ex_vs = '0; ex_hs = '0; ex_val = '0; ex_rd = '0; ex_done = '0; ex_busy = '0;
  endtask

  task automatic mark(inout logic [N-1:0] v, input int idx);
    if (idx >= 0 && idx < N) v[idx] = 1'b1;
  endtask

  // Frame schedule model: state of cycle k appears on post_* at k+2
  task automatic build_exp(input int off);
    int k;
    int x;
    k = off + 1;
    for (int i = 0; i < int'(VL); i++) begin mark(ex_vs, k + 2); k++; end
    for (int y = 0; y < int'(V); y++) begin
      x = 0;
      while (x < int'(H) && k < N) begin
        mark(ex_vs, k + 2); mark(ex_hs, k + 2);
        if (pen_v[k]) begin mark(ex_rd, k); mark(ex_val, k + 2); x++; end
        k++;
      end
      if (y < int'(V) - 1)
        for (int i = 0; i < int'(HB); i++) begin mark(ex_vs, k + 2); k++; end
    end
    for (int i = 0; i < int'(VT); i++) begin mark(ex_vs, k + 2); k++; end
    mark(ex_done, k + 2);
    for (int j = off + 1; j < k + 2; j++) mark(ex_busy, j);
  endtask

  task automatic run_capture(input int n);
    tr_vs = '0; tr_hs = '0; tr_val = '0; tr_rd = '0; tr_done = '0; tr_busy = '0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start  = st_v[k];
      pix_en = pen_v[k];
      if (acc_v[k]) sb_push();
      #1;
      tr_vs[k] = vs; tr_hs[k] = hs; tr_val[k] = val;
      tr_rd[k] = mem_rd_en; tr_done[k] = done; tr_busy[k] = busy;
    end
    @(negedge clk);
    start  = 1'b0;
    pix_en = 1'b1;
  endtask

  task automatic compare_traces(input string t);
    chk({t, ".vsync"}, 64'(tr_vs),   64'(ex_vs));
    chk({t, ".hsync"}, 64'(tr_hs),   64'(ex_hs));
    chk({t, ".valid"}, 64'(tr_val),  64'(ex_val));
    chk({t, ".rd_en"}, 64'(tr_rd),   64'(ex_rd));
    chk({t, ".done"},  64'(tr_done), 64'(ex_done));
    chk({t, ".busy"},  64'(tr_busy), 64'(ex_busy));
  endtask

  function automatic int first_one(input logic [N-1:0] v, input int from);
    for (int i = from; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({vs, hs, val, bitv, busy, done, mem_rd_en, mem_addr});
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  int done_cnt;

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: plain frame with pix_en held high
    clear_vectors();
    st_v[0] = 1'b1; acc_v[0] = 1'b1;
    build_exp(0);
    run_capture(30);
    compare_traces("t1");
    chk("t1.vs_first", 64'(first_one(tr_vs, 0)), 64'(3));
    chk("t1.vs_len",   64'($countones(tr_vs)), 64'(21));
    chk("t1.done_at",  64'(first_one(tr_done, 0)), 64'(24));
    chk("t1.reads",    64'($countones(tr_rd)), 64'(12));
    repeat (3) @(negedge clk);

    // 2: two pix_en gap cycles after the second pixel of line 1
    clear_vectors();
    st_v[0] = 1'b1; acc_v[0] = 1'b1;
    pen_v[12] = 1'b0; pen_v[13] = 1'b0;
    build_exp(0);
    run_capture(32);
    compare_traces("t2");
    chk("t2.vs_len",  64'($countones(tr_vs)), 64'(23));
    chk("t2.done_at", 64'(first_one(tr_done, 0)), 64'(26));
    repeat (3) @(negedge clk);

    // 3: start held through the frame and on its frame_done cycle
    clear_vectors();
    for (int k = 0; k <= 24; k++) st_v[k] = 1'b1;
    acc_v[0] = 1'b1; acc_v[24] = 1'b1;
    build_exp(0);
    build_exp(24);
    run_capture(56);
    compare_traces("t3");
    chk("t3.done_cnt", 64'($countones(tr_done)), 64'(2));
    chk("t3.vs_gap",   64'(first_one(tr_vs, 24) - 24), 64'(3));
    repeat (3) @(negedge clk);

    // 4: asynchronous reset in the middle of line 2, then a clean frame
    clear_vectors();
    st_v[0] = 1'b1; acc_v[0] = 1'b1;
    run_capture(17);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4.async_rst", all_outs(), 64'(0));
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("t4.no_done", 64'(done_cnt), 64'(0));
    chk("t4.idle_outs", all_outs(), 64'(0));
    clear_vectors();
    st_v[0] = 1'b1; acc_v[0] = 1'b1;
    build_exp(0);
    run_capture(30);
    compare_traces("t4b");

    repeat (3) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
